sdm_alloc_ctl: RTL and testbench

Synchronous multi-resource allocator for the SDM router's virtual-circuit pool. It matches N requesting clients to M interchangeable resources, at most one new match per cycle, with round-robin fairness on both sides. It holds each match until the client releases it and drives the M x N configuration matrix that steers the SDM crossbar. It is the clocked counterpart to the asynchronous match arbiter, for use on synchronous router ports and in test harnesses.

---
 rtl/sdm_alloc_pkg.sv | 14 +
 rtl/rr_pick.sv | 43 ++++
 rtl/sdm_alloc_ctl.sv | 144 ++++++++++++++
 tb/tb_sdm_alloc_ctl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sdm_alloc_pkg.sv
// Shared types, defaults and width helper for the SDM virtual-circuit allocator.
package sdm_alloc_pkg;

    localparam int unsigned N_DEF = 4;
    localparam int unsigned M_DEF = 4;

    typedef enum logic {IDLE, HOLD} state_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-one search: picks the first set bit of req at or after ptr, wrapping at W.
module rr_pick
    import sdm_alloc_pkg::*;
#(
    parameter  int unsigned W  = 4,
    localparam int unsigned IW = clog2_min1(W)
) (
    input  logic [W-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [W-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    localparam logic [IW:0] WLIM = (IW+1)'(W);

    logic [2*W-1:0] dbl;
    logic [W-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotate so that bit 0 of rot is the request at ptr.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[W-1:0];

    always_comb begin
        valid = 1'b0;
        off   = '0;
        for (int k = 0; k < W; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= WLIM) begin
            sum = sum - WLIM;
        end
        idx = sum[IW-1:0];
        gnt = valid ? (W'(1) << idx) : '0;
    end

endmodule

// File: rtl/sdm_alloc_ctl.sv
// Round-robin N-client / M-resource allocator holding matches until release and driving
// the M x N crossbar configuration matrix. All outputs come straight from flops.
module sdm_alloc_ctl
    import sdm_alloc_pkg::*;
#(
    parameter  int unsigned N   = N_DEF,
    parameter  int unsigned M   = M_DEF,
    parameter  int unsigned RW  = clog2_min1(M),
    localparam int unsigned NBW = clog2_min1(M + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    c_req,
    input  logic [N-1:0]    c_rel,
    output logic [N-1:0]    c_gnt,
    output logic [N*RW-1:0] c_rid,
    input  logic [M-1:0]    r_avail,
    output logic [M-1:0]    r_busy,
    output logic [M*N-1:0]  cfg,
    output logic [NBW-1:0]  n_busy
);

    localparam int unsigned CPW = clog2_min1(N);
    localparam int unsigned RPW = clog2_min1(M);

    state_t            st_q [N];
    state_t            st_d [N];
    logic [M*N-1:0]    cfg_q, cfg_d;
    logic [N*RW-1:0]   rid_q, rid_d;
    logic [M-1:0]      busy_q, busy_d;
    logic [NBW-1:0]    nb_q, nb_d;
    logic [CPW-1:0]    cp_q, cp_d;
    logic [RPW-1:0]    rp_q, rp_d;

    logic [N-1:0]      c_elig, c_oh;
    logic [M-1:0]      r_elig, r_oh;
    logic [CPW-1:0]    c_idx;
    logic [RPW-1:0]    r_idx;
    logic              c_valid, r_valid, alloc;

    always_comb begin
        for (int j = 0; j < N; j++) begin
            c_elig[j] = c_req[j] && (st_q[j] == IDLE);
        end
    end
    assign r_elig = r_avail & ~busy_q;

    rr_pick #(.W(N)) u_pick_client (
        .req   (c_elig),
        .ptr   (cp_q),
        .gnt   (c_oh),
        .idx   (c_idx),
        .valid (c_valid)
    );

    rr_pick #(.W(M)) u_pick_res (
        .req   (r_elig),
        .ptr   (rp_q),
        .gnt   (r_oh),
        .idx   (r_idx),
        .valid (r_valid)
    );

    assign alloc = c_valid && r_valid;

    always_comb begin
        st_d  = st_q;
        cfg_d = cfg_q;
        rid_d = rid_q;

        // Releases only apply to granted clients; the freed column is cleared outright.
        for (int j = 0; j < N; j++) begin
            if (c_rel[j] && (st_q[j] == HOLD)) begin
                st_d[j] = IDLE;
                for (int i = 0; i < M; i++) begin
                    cfg_d[i*N+j] = 1'b0;
                end
            end
        end

        if (alloc) begin
            for (int j = 0; j < N; j++) begin
                if (c_oh[j]) begin
                    st_d[j]          = HOLD;
                    rid_d[j*RW +: RW] = RW'(r_idx);
                end
                for (int i = 0; i < M; i++) begin
                    if (c_oh[j] && r_oh[i]) begin
                        cfg_d[i*N+j] = 1'b1;
                    end
                end
            end
        end

        nb_d = '0;
        for (int i = 0; i < M; i++) begin
            busy_d[i] = |cfg_d[i*N +: N];
            nb_d      = nb_d + NBW'(busy_d[i]);
        end

        cp_d = cp_q;
        rp_d = rp_q;
        if (alloc) begin
            cp_d = (c_idx == CPW'(N - 1)) ? '0 : c_idx + CPW'(1);
            rp_d = (r_idx == RPW'(M - 1)) ? '0 : r_idx + RPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                st_q[j] <= IDLE;
            end
            cfg_q  <= '0;
            rid_q  <= '0;
            busy_q <= '0;
            nb_q   <= '0;
            cp_q   <= '0;
            rp_q   <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                st_q[j] <= st_d[j];
            end
            cfg_q  <= cfg_d;
            rid_q  <= rid_d;
            busy_q <= busy_d;
            nb_q   <= nb_d;
            cp_q   <= cp_d;
            rp_q   <= rp_d;
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            c_gnt[j] = (st_q[j] == HOLD);
        end
    end

    assign c_rid  = rid_q;
    assign r_busy = busy_q;
    assign cfg    = cfg_q;
    assign n_busy = nb_q;

endmodule

// File: tb/tb_sdm_alloc_ctl.sv
// Scoreboard bench: stimulus pushes expected state from an ownership-table model, a monitor
// pops and compares after every rising clock edge.
module tb_sdm_alloc_ctl;

    localparam int N  = 4;
    localparam int M  = 4;
    localparam int RW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      c_req, c_rel, c_gnt;
    logic [N*RW-1:0]   c_rid;
    logic [M-1:0]      r_avail, r_busy;
    logic [M*N-1:0]    cfg;
    logic [2:0]        n_busy;

    always #5 clk = ~clk;

    sdm_alloc_ctl #(.N(N), .M(M), .RW(RW)) dut (
        .clk     (clk),
        .rst     (rst),
        .c_req   (c_req),
        .c_rel   (c_rel),
        .c_gnt   (c_gnt),
        .c_rid   (c_rid),
        .r_avail (r_avail),
        .r_busy  (r_busy),
        .cfg     (cfg),
        .n_busy  (n_busy)
    );

    typedef struct packed {
        logic [M*N-1:0]  cfg;
        logic [N-1:0]    gnt;
        logic [M-1:0]    busy;
        logic [2:0]      nb;
        logic [N*RW-1:0] rid;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_e;
    logic [N*RW-1:0] mon_mask;
    int gnt_log[$];
    logic [N-1:0] gnt_prev = '0;

    int checks = 0;
    int errors = 0;

    // Model: own[j] = resource held by client j, owner[i] = client holding resource i (-1 = none).
    int own[N];
    int owner[M];
    int cp = 0;
    int rp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] req, input logic [N-1:0] rel,
                         input logic [M-1:0] av);
        int cj, ri, cnt;
        snap_t s;
        rst = r; c_req = req; c_rel = rel; r_avail = av;
        if (r) begin
            for (int j = 0; j < N; j++) own[j] = -1;
            for (int i = 0; i < M; i++) owner[i] = -1;
            cp = 0; rp = 0;
        end else begin
            cj = -1; ri = -1;
            for (int k = 0; k < N; k++)
                if (cj < 0 && req[(cp+k)%N] && own[(cp+k)%N] < 0) cj = (cp + k) % N;
            for (int k = 0; k < M; k++)
                if (ri < 0 && av[(rp+k)%M] && owner[(rp+k)%M] < 0) ri = (rp + k) % M;
            for (int j = 0; j < N; j++)
                if (rel[j] && own[j] >= 0) begin
                    owner[own[j]] = -1;
                    own[j] = -1;
                end
            if (cj >= 0 && ri >= 0) begin
                own[cj] = ri; owner[ri] = cj;
                cp = (cj + 1) % N; rp = (ri + 1) % M;
            end
        end
        s = '0; cnt = 0;
        for (int i = 0; i < M; i++)
            if (owner[i] >= 0) begin
                s.cfg[i*N+owner[i]] = 1'b1;
                s.busy[i] = 1'b1;
                cnt++;
            end
        for (int j = 0; j < N; j++)
            if (own[j] >= 0) begin
                s.gnt[j] = 1'b1;
                s.rid[j*RW +: RW] = RW'(own[j]);
            end
        s.nb = 3'(cnt);
        exp_q.push_back(s);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_mask = '0;
            for (int j = 0; j < N; j++)
                if (mon_e.gnt[j]) mon_mask[j*RW +: RW] = '1;
            check("cfg", 64'(cfg), 64'(mon_e.cfg));
            check("c_gnt", 64'(c_gnt), 64'(mon_e.gnt));
            check("r_busy", 64'(r_busy), 64'(mon_e.busy));
            check("n_busy", 64'(n_busy), 64'(mon_e.nb));
            check("c_rid", 64'(c_rid & mon_mask), 64'(mon_e.rid & mon_mask));
        end
        for (int j = 0; j < N; j++)
            if (c_gnt[j] && !gnt_prev[j]) gnt_log.push_back(j);
        gnt_prev = c_gnt;
    end

    logic [N-1:0] rq, rl;
    logic [M-1:0] av;

    initial begin
        for (int j = 0; j < N; j++) own[j] = -1;
        for (int i = 0; i < M; i++) owner[i] = -1;

        // Full load: grants in order 0..3 with matching resource indices.
        drive(1'b1, '0, '0, '0);
        drive(1'b1, '0, '0, '0);
        gnt_log.delete();
        repeat (4) drive(1'b0, 4'hf, '0, 4'hf);
        check("load_rid", 64'(c_rid), 64'h e4);
        check("load_nbusy", 64'(n_busy), 64'd4);
        check("load_order_n", 64'(gnt_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < gnt_log.size(); k++)
            check("load_order", 64'(gnt_log[k]), 64'(k));

        // Waiting client picks up a resource freed by another client, two cycles later.
        drive(1'b0, 4'b0000, 4'b0100, 4'hf);
        drive(1'b0, 4'b0100, 4'b0000, 4'b1011);
        drive(1'b0, 4'b0100, 4'b0001, 4'b1011);
        check("wait_no_gnt", 64'(c_gnt[2]), 64'd0);
        drive(1'b0, 4'b0100, 4'b0000, 4'b1011);
        check("wait_gnt", 64'(c_gnt[2]), 64'd1);
        check("wait_rid", 64'(c_rid[5:4]), 64'd0);

        // Reset drops three live matches; first grant afterwards is client 0 / resource 0.
        drive(1'b1, 4'hf, 4'h0, 4'hf);
        check("rst_cfg", 64'(cfg), 64'd0);
        check("rst_nbusy", 64'(n_busy), 64'd0);
        drive(1'b0, 4'hf, 4'h0, 4'hf);
        check("post_rst_gnt", 64'(c_gnt), 64'h1);
        check("post_rst_busy", 64'(r_busy), 64'h1);

        // Single available resource contended by clients 1 and 3.
        drive(1'b1, '0, '0, '0);
        drive(1'b0, 4'b1010, 4'b0000, 4'b0100);
        check("one_res_gnt", 64'(c_gnt), 64'b0010);
        check("one_res_rid", 64'(c_rid[3:2]), 64'd2);
        drive(1'b0, 4'b1000, 4'b0000, 4'b0100);
        check("one_res_wait", 64'(c_gnt), 64'b0010);
        drive(1'b0, 4'b1000, 4'b0010, 4'b0100);
        drive(1'b0, 4'b1000, 4'b0000, 4'b0100);
        check("one_res_next", 64'(c_gnt), 64'b1000);
        check("one_res_rid3", 64'(c_rid[7:6]), 64'd2);

        // Fairness over one resource, each owner releasing right after its grant.
        drive(1'b1, '0, '0, '0);
        gnt_log.delete();
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < N; j++) rl[j] = (own[j] >= 0);
            drive(1'b0, 4'hf, rl, 4'b0001);
        end
        check("fair_n", 64'(gnt_log.size() >= 5), 64'd1);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++)
            check("fair_order", 64'(gnt_log[k]), 64'(k % 4));

        // Random traffic including spurious releases and requests held while granted.
        drive(1'b1, '0, '0, '0);
        rq = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int j = 0; j < N; j++) begin
                if (own[j] >= 0) rq[j] = 1'($urandom % 2);
                else             rq[j] = rq[j] | (($urandom % 3) == 0);
                rl[j] = (($urandom % 5) == 0);
            end
            for (int i = 0; i < M; i++) av[i] = (($urandom % 8) != 0);
            drive(($urandom % 200) == 0, rq, rl, av);
        end
        drive(1'b0, '0, '0, '1);
        @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
